// File: rtl/bytewrite_ram_master.sv
// Valid/ready front end for a read-first byte-write BRAM; read data returns through a credit-protected FIFO.
// Optional: define BYTEWRITE_RAM_MASTER_WR_RSP_EN so writes also respond with the pre-write word.
module bytewrite_ram_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [NB_COL-1:0]           cmd_we,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [NB_COL*COL_WIDTH-1:0] cmd_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [NB_COL*COL_WIDTH-1:0] rsp_data,
    output logic [NB_COL-1:0]           ram_we,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [NB_COL*COL_WIDTH-1:0] ram_di,
    input  logic [NB_COL*COL_WIDTH-1:0] ram_do
);
    localparam int DW = NB_COL * COL_WIDTH;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] r_credits;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [DW-1:0] r_mem [RSP_DEPTH];
    logic          r_rd_p1;
    logic          r_rd_p2;

    logic w_accept;
    logic w_rsp_cmd;
    logic w_take_credit;
    logic w_push;
    logic w_pop;

    assign cmd_ready = (r_credits != '0);
    assign w_accept  = cmd_valid && cmd_ready;

`ifdef BYTEWRITE_RAM_MASTER_WR_RSP_EN
    assign w_rsp_cmd = 1'b1;
`else
    assign w_rsp_cmd = (cmd_we == '0);
`endif

    assign w_take_credit = w_accept && w_rsp_cmd;
    assign w_push        = r_rd_p2;
    assign rsp_valid     = (r_count != '0);
    assign w_pop         = rsp_valid && rsp_ready;
    assign rsp_data      = rsp_valid ? r_mem[r_rptr] : '0;

    // A credit is held from accept until the response pops, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= DEPTH_C;
        end else begin
            case ({w_take_credit, w_pop})
                2'b10:   r_credits <= r_credits - ONE_C;
                2'b01:   r_credits <= r_credits + ONE_C;
                default: r_credits <= r_credits;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we   <= '0;
            ram_addr <= '0;
            ram_di   <= '0;
        end else if (w_accept) begin
            ram_we   <= cmd_we;
            ram_addr <= cmd_addr;
            ram_di   <= cmd_wdata;
        end else begin
            ram_we   <= '0;
        end
    end

    // RAM samples one edge after accept and its registered output is captured on the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_p1 <= 1'b0;
            r_rd_p2 <= 1'b0;
        end else begin
            r_rd_p1 <= w_take_credit;
            r_rd_p2 <= r_rd_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= ram_do;
        end
    end

`ifndef SYNTHESIS
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == DEPTH_C)));
`endif

endmodule

// File: tb/tb_bytewrite_ram_master.sv
// Bench for bytewrite_ram_master: behavioural RAM, transaction-level response model and directed tests.
`timescale 1ns/1ps
module tb_bytewrite_ram_master;
    localparam int AW    = 10;
    localparam int CWID  = 8;
    localparam int NC    = 4;
    localparam int DEPTH = 4;
    localparam int DW    = NC * CWID;
`ifdef BYTEWRITE_RAM_MASTER_WR_RSP_EN
    localparam bit WR_RSP = 1'b1;
`else
    localparam bit WR_RSP = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [NC-1:0] cmd_we    = '0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [NC-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do    = '0;

    bytewrite_ram_master #(
        .ADDR_WIDTH(AW),
        .COL_WIDTH (CWID),
        .NB_COL    (NC),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int unsigned cyc     = 0;
    int unsigned run     = 0;
    int unsigned max_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        return DW'(32'hC0DE0000 | a);
    endfunction

    // Read-first RAM with registered output and per-byte write enables.
    logic [DW-1:0] ram_wr [int];
    always @(posedge clk) begin
        logic [DW-1:0] w;
        w = ram_wr.exists(int'(ram_addr)) ? ram_wr[int'(ram_addr)] : init_word(32'(ram_addr));
        ram_do <= w;
        if (ram_we != '0) begin
            for (int c = 0; c < NC; c++)
                if (ram_we[c]) w[c*CWID +: CWID] = ram_di[c*CWID +: CWID];
            ram_wr[int'(ram_addr)] = w;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: golden memory updated in command order, expected responses queued with accept cycle.
    typedef struct {
        logic [DW-1:0] data;
        int unsigned   acc;
    } exp_t;
    exp_t          q[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] gm [int];
    logic          exp_cmd  = 1'b0;
    logic [NC-1:0] exp_we   = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_di   = '0;

    always @(negedge clk) begin
        logic          exp_valid;
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        if (!rst_n) begin
            q.delete();
            exp_cmd = 1'b0;
            exp_we  = '0;
            run     = 0;
            check("rst_ram_we", ram_we, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_rsp_data", rsp_data, 0);
        end else begin
            exp_valid = 1'b0;
            if (q.size() != 0) exp_valid = (cyc >= q[0].acc + 2);
            check("cmd_ready", cmd_ready, q.size() < DEPTH);
            check("rsp_valid", rsp_valid, exp_valid);
            if (rsp_valid && exp_valid) check("rsp_data", rsp_data, q[0].data);
            check("ram_we", ram_we, exp_we);
            if (exp_cmd) begin
                check("ram_addr", ram_addr, exp_addr);
                check("ram_di", ram_di, exp_di);
            end
            run = rsp_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                got.push_back(rsp_data);
                void'(q.pop_front());
            end
            exp_cmd = cmd_valid && cmd_ready;
            exp_we  = exp_cmd ? cmd_we : '0;
            if (exp_cmd) begin
                exp_addr = cmd_addr;
                exp_di   = cmd_wdata;
                old_w = gm.exists(int'(cmd_addr)) ? gm[int'(cmd_addr)] : init_word(32'(cmd_addr));
                new_w = old_w;
                for (int c = 0; c < NC; c++)
                    if (cmd_we[c]) new_w[c*CWID +: CWID] = cmd_wdata[c*CWID +: CWID];
                if (cmd_we == '0 || WR_RSP) q.push_back('{data: old_w, acc: cyc + 1});
                gm[int'(cmd_addr)] = new_w;
            end
        end
    end

    task automatic send(input logic [NC-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int budget, output bit ok);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        ok        = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        cmd_we    = '0;
        cmd_wdata = '0;
    endtask

    task automatic send_ok(input logic [NC-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input string name);
        bit ok;
        send(we, a, d, 4, ok);
        check(name, ok, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int acc;
        int seen;
        int exp_wr_acc;

        // Reset then idle
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_ram_we", ram_we, 0);
        check("idle_ram_addr", ram_addr, 0);
        check("idle_ram_di", ram_di, 0);
        repeat (2) @(posedge clk);
        #1 check("idle_rsp_valid_later", rsp_valid, 0);

        // Full-word write then read-after-write, with literal latency
        rsp_ready = 1'b1;
        got.delete();
        send_ok(4'hF, 10'h010, 32'hDEADBEEF, "t2_wr_accept");
        send_ok(4'h0, 10'h010, 32'h0, "t2_rd_accept");
        check("lat_e0_valid", rsp_valid, 0);
        @(posedge clk); #1;
        check("lat_e1_valid", rsp_valid, WR_RSP);
        @(posedge clk); #1;
        check("lat_e2_valid", rsp_valid, 1);
        check("lat_e2_data", rsp_data, 32'hDEADBEEF);
        drain();
        check("t2_count", got.size(), 1 + WR_RSP);
        if (got.size() == 1 + WR_RSP) check("t2_data", got[got.size()-1], 32'hDEADBEEF);
`ifdef BYTEWRITE_RAM_MASTER_WR_RSP_EN
        if (got.size() == 2) check("t2_wr_rsp", got[0], 32'hC0DE0010);
`endif

        // Single-byte write
        got.delete();
        send_ok(4'b0100, 10'h010, 32'h00AA0000, "t3_wr_accept");
        send_ok(4'h0, 10'h010, 32'h0, "t3_rd_accept");
        drain();
        check("t3_count", got.size(), 1 + WR_RSP);
        if (got.size() == 1 + WR_RSP) check("t3_data", got[got.size()-1], 32'hDEAABEEF);
`ifdef BYTEWRITE_RAM_MASTER_WR_RSP_EN
        if (got.size() == 2) check("t3_wr_rsp", got[0], 32'hDEADBEEF);
`endif

        // Backpressure: only DEPTH reads fit
        rsp_ready = 1'b0;
        got.delete();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(4'h0, AW'(32 + i), 32'h0, 3, ok);
            if (ok) acc++;
        end
        check("bp_accepts", acc, 4);
        check("bp_ready_low", cmd_ready, 0);
        rsp_ready = 1'b1;
        drain();
        check("bp_ready_back", cmd_ready, 1);
        check("bp_count", got.size(), 4);
        if (got.size() == 4)
            for (int i = 0; i < 4; i++) check("bp_order", got[i], 32'hC0DE0020 + 32'(i));

        // Streaming 16 reads
        got.delete();
        max_run = 0;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            send(4'h0, AW'(i), 32'h0, 2, ok);
            if (ok) acc++;
        end
        drain();
        check("st_accepts", acc, 16);
        check("st_valid_run", max_run, 16);
        check("st_count", got.size(), 16);
        if (got.size() == 16)
            for (int i = 0; i < 16; i++) check("st_data", got[i], 32'hC0DE0000 + 32'(i));

        // Reset asserted right after a write accept: write enable drops asynchronously
        got.delete();
        send_ok(4'hF, 10'h030, 32'hC0DE0030, "rst_wr_accept");
        check("wr_issued", ram_we, 4'hF);
        rst_n = 1'b0;
        #1;
        check("async_we_drop", ram_we, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset mid-burst discards in-flight reads
        send_ok(4'h0, 10'h001, 32'h0, "mid_rd0");
        send_ok(4'h0, 10'h002, 32'h0, "mid_rd1");
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        @(posedge clk); #1;
        check("mid_rst_no_rsp", seen, 0);
        check("mid_rst_ram_we", ram_we, 0);
        rsp_ready = 1'b0;
        got.delete();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            send(4'h0, AW'(64 + i), 32'h0, 2, ok);
            if (ok) acc++;
        end
        check("post_rst_credits", acc, 4);
        rsp_ready = 1'b1;
        drain();
        check("post_rst_count", got.size(), 4);
        if (got.size() == 4) check("post_rst_first", got[0], 32'hC0DE0040);

        // Write over 0xDEAABEEF then read back
        got.delete();
        send_ok(4'hF, 10'h010, 32'h11223344, "t7_wr_accept");
        send_ok(4'h0, 10'h010, 32'h0, "t7_rd_accept");
        drain();
`ifdef BYTEWRITE_RAM_MASTER_WR_RSP_EN
        check("t7_count", got.size(), 2);
        if (got.size() == 2) begin
            check("t7_wr_rsp", got[0], 32'hDEAABEEF);
            check("t7_rd_rsp", got[1], 32'h11223344);
        end
        exp_wr_acc = 4;
`else
        check("t7_count", got.size(), 1);
        if (got.size() == 1) check("t7_rd_rsp", got[0], 32'h11223344);
        exp_wr_acc = 6;
`endif

        // Writes under backpressure: credit use depends on write responses
        rsp_ready = 1'b0;
        got.delete();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(4'hF, AW'(256 + i), 32'h5A000000 + 32'(i), 2, ok);
            if (ok) acc++;
        end
        check("wr_bp_accepts", acc, exp_wr_acc);
        rsp_ready = 1'b1;
        drain();
        check("wr_bp_ready", cmd_ready, 1);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
